// File: rtl/inst_encoder_pkg.sv
// Shared opcode constants, format classes and immediate-range helpers for the
// RV32I instruction encoder.
package inst_encoder_pkg;

    localparam logic [6:0] OP_ITYPEL = 7'h03;
    localparam logic [6:0] OP_ITYPEA = 7'h13;
    localparam logic [6:0] OP_ITYPEJ = 7'h67;
    localparam logic [6:0] OP_STYPE  = 7'h23;
    localparam logic [6:0] OP_BTYPE  = 7'h63;
    localparam logic [6:0] OP_UTYPEL = 7'h37;
    localparam logic [6:0] OP_UTYPEU = 7'h17;
    localparam logic [6:0] OP_JTYPE  = 7'h6F;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_BAD = 3'd7
    } fmt_e;

    function automatic fmt_e op_class(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_ITYPEL, OP_ITYPEA, OP_ITYPEJ: f = FMT_I;
            OP_STYPE:                        f = FMT_S;
            OP_BTYPE:                        f = FMT_B;
            OP_UTYPEL, OP_UTYPEU:            f = FMT_U;
            OP_JTYPE:                        f = FMT_J;
            default:                         f = FMT_BAD;
        endcase
        return f;
    endfunction

    // A value fits a signed N-bit field when all bits above N-1 copy the sign bit.
    function automatic logic imm_fits(input fmt_e f, input logic [31:0] imm);
        logic ok;
        case (f)
            FMT_I, FMT_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
            FMT_B:        ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            FMT_U:        ok = ~(|imm[11:0]);
            FMT_J:        ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational packer: format class, register fields and immediate to a
// 32-bit RV32I word; rejected requests collapse to the NOP word.
module inst_pack_fmt
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  fmt_e        fmt,
    input  logic        legal,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  f3,
    input  logic [31:0] imm,
    output logic [31:0] inst
);

    always_comb begin
        inst = NOP_INST;
        if (legal) begin
            case (fmt)
                FMT_I:   inst = {imm[11:0], rs1, f3, rd, op};
                FMT_S:   inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                FMT_B:   inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                FMT_U:   inst = {imm[31:12], rd, op};
                FMT_J:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                default: inst = NOP_INST;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: S1 classifies and range-checks the
// immediate, S2 packs the word and counts rejected requests.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic        s1_v, s2_v, s1_adv, s2_adv;
    fmt_e        in_fmt, s1_fmt;
    logic        s1_legal;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [2:0]  s1_f3;
    logic [31:0] s1_imm;
    logic [31:0] pack_word;
    logic        funct7_unused;

    // funct7 is reserved: no handled format carries it.
    assign funct7_unused = ^in_funct7;

    // Valid/ready: a transfer happens on a rising edge where valid & ready are
    // both 1; valid and its payload stay put until then. Each stage moves when
    // it is empty or its successor moves, so in_ready follows out_ready
    // combinationally and a full pipe streams one word per cycle.
    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;
    assign in_fmt    = op_class(in_opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_fmt   <= FMT_BAD;
            s1_legal <= 1'b0;
            s1_op    <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_imm   <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_fmt   <= in_fmt;
                s1_legal <= imm_fits(in_fmt, in_imm);
                s1_op    <= in_opcode;
                s1_rd    <= in_rd;
                s1_rs1   <= in_rs1;
                s1_rs2   <= in_rs2;
                s1_f3    <= in_funct3;
                s1_imm   <= in_imm;
            end
        end
    end

    inst_pack_fmt #(
        .NOP_INST (NOP_INST)
    ) u_pack (
        .fmt   (s1_fmt),
        .legal (s1_legal),
        .op    (s1_op),
        .rd    (s1_rd),
        .rs1   (s1_rs1),
        .rs2   (s1_rs2),
        .f3    (s1_f3),
        .imm   (s1_imm),
        .inst  (pack_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            out_inst <= '0;
            out_err  <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_inst <= pack_word;
                out_err  <= !s1_legal;
            end
        end
    end

    // Counted when the rejected word leaves, so a stalled reject counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (s2_v && out_ready && out_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
